// File: rtl/axistream_merger.sv
// Two-way merge of ascending AXI-stream packets into one ascending packet.
// When one input's last word is popped, the other input is drained to finish the output packet.
module axistream_merger #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_tvalid,
    output logic                  a_tready,
    input  logic [DATA_WIDTH-1:0] a_tdata,
    input  logic                  a_tlast,
    input  logic                  b_tvalid,
    output logic                  b_tready,
    input  logic [DATA_WIDTH-1:0] b_tdata,
    input  logic                  b_tlast,
    output logic                  dest_tvalid,
    input  logic                  dest_tready,
    output logic [DATA_WIDTH-1:0] dest_tdata,
    output logic                  dest_tlast
);

    typedef enum logic [1:0] {
        MERGE   = 2'b00,
        DRAIN_A = 2'b01,
        DRAIN_B = 2'b10
    } state_t;

    state_t state;
    state_t state_next;
    logic   load;
    logic   take_a;
    logic   take_b;
    logic   tlast_in;

    assign load = !dest_tvalid || dest_tready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= MERGE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            MERGE: begin
                if (take_a && a_tlast) begin
                    state_next = DRAIN_B;
                end else if (take_b && b_tlast) begin
                    state_next = DRAIN_A;
                end
            end
            DRAIN_A: begin
                if (take_a && a_tlast) begin
                    state_next = MERGE;
                end
            end
            DRAIN_B: begin
                if (take_b && b_tlast) begin
                    state_next = MERGE;
                end
            end
            default: state_next = MERGE;
        endcase
    end

    // Pop selection; held at zero while reset is asserted.
    always_comb begin
        take_a = 1'b0;
        take_b = 1'b0;
        if (rst) begin
            case (state)
                MERGE: begin
                    if (a_tvalid && b_tvalid && load) begin
                        if (a_tdata <= b_tdata) begin
                            take_a = 1'b1;
                        end else begin
                            take_b = 1'b1;
                        end
                    end
                end
                DRAIN_A: take_a = load && a_tvalid;
                DRAIN_B: take_b = load && b_tvalid;
                default: begin
                    take_a = 1'b0;
                    take_b = 1'b0;
                end
            endcase
        end
    end

    assign a_tready = take_a;
    assign b_tready = take_b;
    assign tlast_in = take_a ? a_tlast : b_tlast;

    // Output tlast only comes from the drain phase, where the final word of the merge is popped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dest_tvalid <= 1'b0;
            dest_tdata  <= '0;
            dest_tlast  <= 1'b0;
        end else if (load) begin
            dest_tvalid <= take_a || take_b;
            if (take_a || take_b) begin
                dest_tdata <= take_a ? a_tdata : b_tdata;
                dest_tlast <= ((state == DRAIN_A) || (state == DRAIN_B)) && tlast_in;
            end
        end
    end

endmodule

// File: tb/tb_axistream_merger.sv
// Scoreboard bench for axistream_merger: packet-level merge model feeds an expected-word queue.
// Inputs change on the falling edge; outputs are sampled shortly after it.
module tb_axistream_merger;

    localparam int unsigned DW = 8;
    typedef logic [DW:0] word_t;  // {tlast, tdata}

    logic          clk = 1'b0;
    logic          rst;
    logic          a_tvalid, a_tready, a_tlast;
    logic [DW-1:0] a_tdata;
    logic          b_tvalid, b_tready, b_tlast;
    logic [DW-1:0] b_tdata;
    logic          dest_tvalid, dest_tready, dest_tlast;
    logic [DW-1:0] dest_tdata;

    int unsigned   checks = 0;
    int unsigned   errors = 0;
    int unsigned   out_cnt = 0;
    int unsigned   cyc = 0;
    bit            bp_mode = 1'b0;
    bit            abort = 1'b0;
    word_t         sb[$];
    int unsigned   hs_cyc[$];
    logic [31:0]   pop_bits = '0;

    axistream_merger #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .a_tvalid(a_tvalid), .a_tready(a_tready), .a_tdata(a_tdata), .a_tlast(a_tlast),
        .b_tvalid(b_tvalid), .b_tready(b_tready), .b_tdata(b_tdata), .b_tlast(b_tlast),
        .dest_tvalid(dest_tvalid), .dest_tready(dest_tready),
        .dest_tdata(dest_tdata), .dest_tlast(dest_tlast)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference merge at packet level: ascending pick, ties to A, tlast only on the final word.
    task automatic expect_merge(input word_t a[$], input word_t b[$]);
        int unsigned i = 0;
        int unsigned j = 0;
        int unsigned n = a.size() + b.size();
        logic [DW-1:0] d;
        while (i < a.size() || j < b.size()) begin
            if (j >= b.size() || (i < a.size() && a[i][DW-1:0] <= b[j][DW-1:0])) begin
                d = a[i][DW-1:0];
                i++;
            end else begin
                d = b[j][DW-1:0];
                j++;
            end
            sb.push_back({((i + j) == n), d});
        end
    endtask

    task automatic send_a(input word_t pkt[$]);
        bit ok;
        int unsigned n;
        foreach (pkt[k]) begin
            a_tvalid = 1'b1;
            {a_tlast, a_tdata} = pkt[k];
            n = 0;
            do begin
                #1 ok = a_tready;
                @(negedge clk);
                if (abort) begin
                    a_tvalid = 1'b0;
                    return;
                end
                n++;
            end while (!ok && n < 200);
            check("a_accept", 32'(ok), 1);
            pop_bits = {pop_bits[30:0], 1'b1};
        end
        a_tvalid = 1'b0;
    endtask

    task automatic send_b(input word_t pkt[$]);
        bit ok;
        int unsigned n;
        foreach (pkt[k]) begin
            b_tvalid = 1'b1;
            {b_tlast, b_tdata} = pkt[k];
            n = 0;
            do begin
                #1 ok = b_tready;
                @(negedge clk);
                if (abort) begin
                    b_tvalid = 1'b0;
                    return;
                end
                n++;
            end while (!ok && n < 200);
            check("b_accept", 32'(ok), 1);
            pop_bits = {pop_bits[30:0], 1'b0};
        end
        b_tvalid = 1'b0;
    endtask

    task automatic drain_wait();
        int unsigned n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic run_pair(input word_t a[$], input word_t b[$]);
        expect_merge(a, b);
        fork
            send_a(a);
            send_b(b);
        join
        drain_wait();
    endtask

    // Downstream ready: constant 1, or the 1,0,0 repeating backpressure pattern.
    initial begin
        int unsigned k = 0;
        dest_tready = 1'b1;
        forever begin
            @(negedge clk);
            if (bp_mode) begin
                dest_tready = (k % 3 == 0);
                k++;
            end else begin
                dest_tready = 1'b1;
            end
        end
    end

    // Output monitor: scoreboard compare on handshake, stability and no-pop checks during stalls.
    initial begin
        bit            hold_v = 1'b0;
        logic [DW-1:0] hold_d;
        logic          hold_l;
        word_t         e;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (rst && hold_v) begin
                check("hold_valid", 32'(dest_tvalid), 1);
                check("hold_data", 32'(dest_tdata), 32'(hold_d));
                check("hold_last", 32'(dest_tlast), 32'(hold_l));
            end
            hold_v = 1'b0;
            if (rst && dest_tvalid && dest_tready) begin
                if (sb.size() == 0) begin
                    check("extra_word", 32'(dest_tdata), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("data", 32'(dest_tdata), 32'(e[DW-1:0]));
                    check("last", 32'(dest_tlast), 32'(e[DW]));
                end
                hs_cyc.push_back(cyc);
                out_cnt++;
            end else if (rst && dest_tvalid) begin
                hold_v = 1'b1;
                hold_d = dest_tdata;
                hold_l = dest_tlast;
                check("no_pop_full", {30'd0, a_tready, b_tready}, 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        word_t a[$];
        word_t b[$];
        word_t a2[$];
        word_t b2[$];
        int unsigned base;

        rst = 1'b0;
        a_tvalid = 1'b1; a_tdata = '0; a_tlast = 1'b0;
        b_tvalid = 1'b1; b_tdata = '0; b_tlast = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_dvalid", 32'(dest_tvalid), 0);
        check("rst_ddata", 32'(dest_tdata), 0);
        check("rst_dlast", 32'(dest_tlast), 0);
        check("rst_ardy", 32'(a_tready), 0);
        check("rst_brdy", 32'(b_tready), 0);
        a_tvalid = 1'b0;
        b_tvalid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Basic merge, full rate.
        a = '{9'h001, 9'h004, 9'h109};
        b = '{9'h002, 9'h003, 9'h10A};
        hs_cyc.delete();
        run_pair(a, b);
        check("basic_count", hs_cyc.size(), 6);
        if (hs_cyc.size() == 6) check("basic_burst", hs_cyc[5] - hs_cyc[0], 5);

        // Ties and single-word packets, back to back.
        a = '{9'h005, 9'h105};
        b = '{9'h105};
        a2 = '{9'h107};
        b2 = '{9'h103};
        expect_merge(a, b);
        expect_merge(a2, b2);
        pop_bits = '0;
        fork
            begin send_a(a); send_a(a2); end
            begin send_b(b); send_b(b2); end
        join
        drain_wait();
        check("tie_order", pop_bits, 32'b11001);

        // Drain path.
        a = '{9'h100};
        b = '{9'h001, 9'h002, 9'h003, 9'h104};
        hs_cyc.delete();
        run_pair(a, b);
        check("drain_count", hs_cyc.size(), 5);
        if (hs_cyc.size() == 5) check("drain_burst", hs_cyc[4] - hs_cyc[0], 4);

        // Backpressure.
        bp_mode = 1'b1;
        a = '{9'h001, 9'h004, 9'h109};
        b = '{9'h002, 9'h003, 9'h10A};
        run_pair(a, b);
        bp_mode = 1'b0;
        repeat (2) @(negedge clk);

        // Input starvation.
        a = '{9'h001, 9'h103};
        b = '{9'h102};
        expect_merge(a, b);
        fork
            send_a(a);
            begin
                for (int i = 0; i < 5; i++) begin
                    #1;
                    check("starve_ardy", 32'(a_tready), 0);
                    check("starve_out", 32'(dest_tvalid), 0);
                    @(negedge clk);
                end
                send_b(b);
            end
        join
        drain_wait();

        // Asynchronous reset mid-packet.
        a = '{9'h001, 9'h004, 9'h109};
        b = '{9'h002, 9'h003, 9'h10A};
        expect_merge(a, b);
        base = out_cnt;
        fork
            send_a(a);
            send_b(b);
            begin
                int unsigned n = 0;
                while (out_cnt < base + 2 && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                check("rst_progress", 32'(out_cnt - base >= 2), 1);
                #3 rst = 1'b0;
                #1;
                check("arst_dvalid", 32'(dest_tvalid), 0);
                check("arst_ardy", 32'(a_tready), 0);
                check("arst_brdy", 32'(b_tready), 0);
                abort = 1'b1;
                repeat (3) @(negedge clk);
                sb.delete();
                rst = 1'b1;
                abort = 1'b0;
            end
        join
        @(negedge clk);
        a = '{9'h108};
        b = '{9'h106};
        run_pair(a, b);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
